// File: rtl/seed_mode_ctrl.sv
// -----------------------------------------------------------------------------
// seed_mode_ctrl
//
// Mode-of-operation wrapper around an iterative SEED-128 core. Input blocks
// arrive on a valid/ready stream and land in a small FIFO. Each block is run
// through the core in ECB, CBC or CTR mode, encrypting or decrypting. A result
// is held on o_Data/o_fValid until the downstream side accepts it.
//
// Core protocol: the block (or counter) goes out on o_CoreData in the cycle
// where o_CoreStart is high. The key follows on o_CoreData in the next cycle.
// The controller then waits for i_CoreDone. A watchdog abandons a block whose
// core never answers.
//
// Ports:
//   Clk, Rst                  clock, asynchronous active-high reset
//   i_fInit                   load key/IV/mode/direction (honoured in IDLE)
//   i_Key, i_IV               cipher key, IV / initial counter block
//   i_Mode, i_fDec            00 ECB, 01 CBC, 10 CTR; 1 = decrypt
//   i_Data, i_fValid          input block stream
//   o_fReady                  FIFO has room (registered)
//   o_Data, o_fValid          result block, held until i_fOutReady
//   i_fOutReady               downstream accepts the result
//   o_CoreData                core data/key bus
//   o_CoreStart, o_CoreDec    core start pulse and direction
//   i_CoreData, i_CoreDone    core result and done pulse
//   o_fBusy                   sequencer not idle
//   o_fErr                    sticky error (bad init, timeout)
// -----------------------------------------------------------------------------
module seed_mode_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CTR_W      = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         i_fInit,
  input  logic [127:0] i_Key,
  input  logic [127:0] i_IV,
  input  logic [1:0]   i_Mode,
  input  logic         i_fDec,
  input  logic [127:0] i_Data,
  input  logic         i_fValid,
  output logic         o_fReady,
  output logic [127:0] o_Data,
  output logic         o_fValid,
  input  logic         i_fOutReady,
  output logic [127:0] o_CoreData,
  output logic         o_CoreStart,
  output logic         o_CoreDec,
  input  logic [127:0] i_CoreData,
  input  logic         i_CoreDone,
  output logic         o_fBusy,
  output logic         o_fErr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_BLK = 3'd1;
  localparam logic [2:0] S_LOAD_KEY = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_OUT      = 3'd4;

  localparam logic [1:0] M_ECB = 2'b00;
  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CTR = 2'b10;
  localparam logic [1:0] M_RSV = 2'b11;

  logic [2:0]     state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           ready_q, ready_d;
  logic [127:0]   key_q, key_d;
  logic [1:0]     mode_q, mode_d;
  logic           dec_q, dec_d;
  logic           cfg_valid_q, cfg_valid_d;
  // CBC chaining value or CTR counter block; only one is live per config.
  logic [127:0]   chain_q, chain_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [127:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;

  logic [127:0]   fifo_mem [FIFO_DEPTH];
  logic [127:0]   blk_q;
  logic           push;
  logic           pop;
  logic [127:0]   ctr_next;

  assign push = i_fValid && ready_q;

  // FIFO storage and registered read of the popped block; no reset so the
  // array maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr_q] <= i_Data;
    if (pop)  blk_q <= fifo_mem[rd_ptr_q];
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    key_d       = key_q;
    mode_d      = mode_q;
    dec_d       = dec_q;
    cfg_valid_d = cfg_valid_q;
    chain_d     = chain_q;
    timer_d     = timer_q;
    data_d      = data_q;
    valid_d     = valid_q;
    err_d       = err_q;
    pop         = 1'b0;

    // Only the low CTR_W bits count; the upper part of the block is fixed.
    ctr_next = chain_q;
    ctr_next[CTR_W-1:0] = chain_q[CTR_W-1:0] + CTR_W'(1);

    case (state_q)
      S_IDLE: begin
        // Init takes priority; a pending pop simply waits a cycle.
        if (i_fInit) begin
          if (i_Mode == M_RSV) begin
            err_d       = 1'b1;
            cfg_valid_d = 1'b0;
          end else begin
            key_d       = i_Key;
            mode_d      = i_Mode;
            dec_d       = i_fDec;
            chain_d     = i_IV;
            cfg_valid_d = 1'b1;
            err_d       = 1'b0;
          end
        end else if (cfg_valid_q && (count_q != '0) && !valid_q) begin
          pop     = 1'b1;
          state_d = S_LOAD_BLK;
        end
      end
      S_LOAD_BLK: state_d = S_LOAD_KEY;
      S_LOAD_KEY: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        if (i_CoreDone) begin
          valid_d = 1'b1;
          state_d = S_OUT;
          case (mode_q)
            M_ECB: data_d = i_CoreData;
            M_CBC: begin
              if (dec_q) begin
                data_d  = i_CoreData ^ chain_q;
                chain_d = blk_q;
              end else begin
                data_d  = i_CoreData;
                chain_d = i_CoreData;
              end
            end
            M_CTR: begin
              data_d  = blk_q ^ i_CoreData;
              chain_d = ctr_next;
            end
            default: data_d = i_CoreData;
          endcase
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Hung core: drop the block, keep chain/counter as they were.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_OUT: begin
        if (i_fOutReady) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_fInit && (state_q != S_IDLE)) err_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
    ready_d = (count_d != (AW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      key_q       <= '0;
      mode_q      <= M_ECB;
      dec_q       <= 1'b0;
      cfg_valid_q <= 1'b0;
      chain_q     <= '0;
      timer_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      dec_q       <= dec_d;
      cfg_valid_q <= cfg_valid_d;
      chain_q     <= chain_d;
      timer_q     <= timer_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    o_CoreData = '0;
    case (state_q)
      S_LOAD_BLK: begin
        case (mode_q)
          M_CBC:   o_CoreData = dec_q ? blk_q : (blk_q ^ chain_q);
          M_CTR:   o_CoreData = chain_q;
          default: o_CoreData = blk_q;
        endcase
      end
      S_LOAD_KEY: o_CoreData = key_q;
      default:    o_CoreData = '0;
    endcase
  end

  assign o_CoreStart = (state_q == S_LOAD_BLK);
  assign o_CoreDec   = (state_q != S_IDLE) && dec_q && (mode_q != M_CTR);
  assign o_fReady    = ready_q;
  assign o_Data      = data_q;
  assign o_fValid    = valid_q;
  assign o_fBusy     = (state_q != S_IDLE);
  assign o_fErr      = err_q;

endmodule

// File: tb/tb_seed_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seed_mode_ctrl
//
// Directed bench for seed_mode_ctrl. The core is replaced by a small
// invertible stand-in cipher (rotate-left-by-one then XOR key), so mode
// results can be derived in the bench without a full SEED implementation.
// -----------------------------------------------------------------------------
module tb_seed_mode_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int CTR_W      = 32;
  localparam int TIMEOUT    = 64;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         i_fInit;
  logic [127:0] i_Key, i_IV;
  logic [1:0]   i_Mode;
  logic         i_fDec;
  logic [127:0] i_Data;
  logic         i_fValid;
  logic         o_fReady;
  logic [127:0] o_Data;
  logic         o_fValid;
  logic         i_fOutReady;
  logic [127:0] o_CoreData;
  logic         o_CoreStart;
  logic         o_CoreDec;
  logic [127:0] i_CoreData;
  logic         i_CoreDone;
  logic         o_fBusy;
  logic         o_fErr;

  seed_mode_ctrl #(
    .FIFO_DEPTH(FIFO_DEPTH), .CTR_W(CTR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Rst(Rst), .i_fInit(i_fInit), .i_Key(i_Key), .i_IV(i_IV),
    .i_Mode(i_Mode), .i_fDec(i_fDec), .i_Data(i_Data), .i_fValid(i_fValid),
    .o_fReady(o_fReady), .o_Data(o_Data), .o_fValid(o_fValid),
    .i_fOutReady(i_fOutReady), .o_CoreData(o_CoreData),
    .o_CoreStart(o_CoreStart), .o_CoreDec(o_CoreDec),
    .i_CoreData(i_CoreData), .i_CoreDone(i_CoreDone),
    .o_fBusy(o_fBusy), .o_fErr(o_fErr)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  function automatic logic [127:0] core_enc(input logic [127:0] x, input logic [127:0] k);
    return {x[126:0], x[127]} ^ k;
  endfunction

  function automatic logic [127:0] core_dec(input logic [127:0] y, input logic [127:0] k);
    logic [127:0] t;
    t = y ^ k;
    return {t[0], t[127:1]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Core stand-in: captures block and key at the falling edge, answers
  // core_lat cycles later unless core_hold is set.
  logic [127:0] cap_blk, cap_prev, cap_key;
  logic         cap_dec;
  int           n_start = 0;
  int           n_key   = 0;
  int           core_lat = 3;
  logic         core_hold = 1'b0;

  initial begin
    i_CoreDone = 1'b0;
    i_CoreData = '0;
    cap_blk = '0; cap_prev = '0; cap_key = '0; cap_dec = 1'b0;
    forever begin
      @(negedge Clk);
      if (o_CoreStart) begin
        cap_prev = cap_blk;
        cap_blk  = o_CoreData;
        cap_dec  = o_CoreDec;
        n_start++;
        @(negedge Clk);
        cap_key = o_CoreData;
        n_key++;
        repeat (core_lat) @(negedge Clk);
        if (!core_hold) begin
          i_CoreData = cap_dec ? core_dec(cap_blk, cap_key) : core_enc(cap_blk, cap_key);
          i_CoreDone = 1'b1;
          @(negedge Clk);
          i_CoreDone = 1'b0;
        end
      end
    end
  end

  task automatic do_init(input logic [1:0] m, input logic d, input logic [127:0] k,
                         input logic [127:0] iv);
    @(negedge Clk);
    i_Mode = m; i_fDec = d; i_Key = k; i_IV = iv; i_fInit = 1'b1;
    @(negedge Clk);
    i_fInit = 1'b0;
  endtask

  task automatic push(input logic [127:0] d);
    int n;
    n = 0;
    @(negedge Clk);
    while (!o_fReady && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk("push_ready", o_fReady, 1);
    i_Data = d; i_fValid = 1'b1;
    @(negedge Clk);
    i_fValid = 1'b0;
  endtask

  task automatic get_out(output logic [127:0] d);
    int n;
    n = 0;
    while (!o_fValid && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk("out_valid", o_fValid, 1);
    d = o_Data;
    i_fOutReady = 1'b1;
    @(negedge Clk);
    i_fOutReady = 1'b0;
  endtask

  task automatic wait_key(input int k0);
    int n;
    n = 0;
    while (n_key == k0 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk("core_key_seen", (n_key != k0), 1);
  endtask

  logic [127:0] p [5];
  logic [127:0] c [5];
  logic [127:0] r, ch, k, iv, d0;
  logic         stable;
  int           s0, k0, n;

  initial begin
    Rst = 1'b1; i_fInit = 1'b0; i_Key = '0; i_IV = '0; i_Mode = 2'b00;
    i_fDec = 1'b0; i_Data = '0; i_fValid = 1'b0; i_fOutReady = 1'b0;

    // Reset state
    #2;
    chk("rst_ready", o_fReady, 0);
    chk("rst_valid", o_fValid, 0);
    chk("rst_busy", o_fBusy, 0);
    chk("rst_err", o_fErr, 0);
    chk("rst_data", o_Data, 0);
    chk("rst_start", o_CoreStart, 0);
    chk("rst_coredata", o_CoreData, 0);
    @(negedge Clk); Rst = 1'b0;
    @(negedge Clk);
    chk("ready_after_rst", o_fReady, 1);

    // ECB encrypt, key 0
    p[0] = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    do_init(2'b00, 1'b0, '0, '0);
    push(p[0]);
    get_out(r);
    chk("ecb_enc", r, core_enc(p[0], '0));
    chk("ecb_start_blk", cap_blk, p[0]);
    chk("ecb_key_cycle", cap_key, 0);
    chk("ecb_enc_dir", cap_dec, 0);

    // ECB decrypt
    k = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    p[0] = 128'hC11F22F2_01405050_84483597_E4370F43;
    do_init(2'b00, 1'b1, k, '0);
    push(p[0]);
    get_out(r);
    chk("ecb_dec", r, core_dec(p[0], k));
    chk("ecb_dec_dir", cap_dec, 1);
    chk("ecb_dec_key", cap_key, k);

    // CBC encrypt then decrypt, 3 blocks
    k  = 128'h47064808_51E61BE8_5D74BFB3_FD956185;
    iv = 128'h83A2F8A2_88641FB9_A4E9A5CC_2F131C7D;
    p[0] = 128'h0;
    p[1] = 128'h11111111_22222222_33333333_44444444;
    p[2] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    do_init(2'b01, 1'b0, k, iv);
    for (int i = 0; i < 3; i++) push(p[i]);
    ch = iv;
    for (int i = 0; i < 3; i++) begin
      get_out(c[i]);
      chk($sformatf("cbc_enc%0d", i), c[i], core_enc(p[i] ^ ch, k));
      ch = core_enc(p[i] ^ ch, k);
    end
    do_init(2'b01, 1'b1, k, iv);
    for (int i = 0; i < 3; i++) push(c[i]);
    for (int i = 0; i < 3; i++) begin
      get_out(r);
      chk($sformatf("cbc_dec%0d", i), r, p[i]);
    end

    // CTR with counter wrap; i_fDec must be ignored
    iv = 128'h01020304_05060708_090A0B0C_FFFFFFFF;
    do_init(2'b10, 1'b1, k, iv);
    push(p[1]); push(p[2]);
    get_out(c[0]); get_out(c[1]);
    chk("ctr_ct0", c[0], p[1] ^ core_enc(iv, k));
    chk("ctr_ct1", c[1], p[2] ^ core_enc(128'h01020304_05060708_090A0B0C_00000000, k));
    chk("ctr_blk0", cap_prev, iv);
    chk("ctr_blk1_wrap", cap_blk, 128'h01020304_05060708_090A0B0C_00000000);
    chk("ctr_dir", cap_dec, 0);
    do_init(2'b10, 1'b0, k, iv);
    push(c[0]); push(c[1]);
    get_out(r); chk("ctr_rt0", r, p[1]);
    get_out(r); chk("ctr_rt1", r, p[2]);

    // Backpressure: one block parked in OUT, FIFO full behind it
    do_init(2'b00, 1'b0, k, '0);
    for (int i = 0; i < 5; i++) begin
      p[i] = {4{32'h1000_0000 + 32'(i)}};
      push(p[i]);
    end
    chk("bp_full", o_fReady, 0);
    d0 = o_Data; s0 = n_start; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (o_Data !== d0 || !o_fValid) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_no_pop", n_start, s0);
    for (int i = 0; i < 5; i++) begin
      get_out(r);
      chk($sformatf("bp_order%0d", i), r, core_enc(p[i], k));
    end

    // Watchdog: core withholds done
    core_hold = 1'b1;
    k0 = n_key;
    push(128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0);
    wait_key(k0);
    repeat (TIMEOUT / 2) @(negedge Clk);
    chk("wd_not_early", o_fErr, 0);
    n = 0;
    while (!o_fErr && n < TIMEOUT + 20) begin
      @(negedge Clk);
      n++;
    end
    chk("wd_err", o_fErr, 1);
    chk("wd_idle", o_fBusy, 0);
    chk("wd_dropped", o_fValid, 0);
    core_hold = 1'b0;
    repeat (core_lat + 2) @(negedge Clk);
    do_init(2'b00, 1'b0, k, '0);
    chk("wd_err_clear", o_fErr, 0);
    push(p[3]);
    get_out(r);
    chk("wd_next_blk", r, core_enc(p[3], k));

    // Init during WAIT: flagged and ignored
    core_lat = 10;
    k0 = n_key;
    push(p[1]);
    wait_key(k0);
    do_init(2'b01, 1'b1, 128'h55, 128'h66);
    chk("init_wait_err", o_fErr, 1);
    get_out(r);
    chk("init_wait_blk", r, core_enc(p[1], k));
    push(p[2]);
    get_out(r);
    chk("init_wait_cfg", r, core_enc(p[2], k));
    chk("init_wait_key", cap_key, k);
    chk("err_sticky", o_fErr, 1);
    core_lat = 3;

    // Reserved mode
    do_init(2'b00, 1'b0, k, '0);
    chk("err_cleared", o_fErr, 0);
    do_init(2'b11, 1'b0, k, '0);
    chk("rsv_err", o_fErr, 1);
    s0 = n_start;
    push(p[4]);
    repeat (20) @(negedge Clk);
    chk("rsv_no_start", n_start, s0);
    chk("rsv_idle", o_fBusy, 0);
    do_init(2'b00, 1'b0, k, '0);
    get_out(r);
    chk("rsv_kept_blk", r, core_enc(p[4], k));
    chk("rsv_err_clear", o_fErr, 0);

    // Reset in the middle of WAIT
    core_lat = 10;
    k0 = n_key;
    push(p[0]);
    wait_key(k0);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("rst_mid_busy", o_fBusy, 0);
    chk("rst_mid_data", o_Data, 0);
    chk("rst_mid_valid", o_fValid, 0);
    chk("rst_mid_ready", o_fReady, 0);
    chk("rst_mid_coredata", o_CoreData, 0);
    chk("rst_mid_start", o_CoreStart, 0);
    chk("rst_mid_dec", o_CoreDec, 0);
    chk("rst_mid_err", o_fErr, 0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (20) @(negedge Clk);
    chk("rst_done_ignored", o_fValid, 0);
    chk("rst_stays_idle", o_fBusy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
